ram_rw_responder: RTL



---
 rtl/ram_rw_responder_if.sv | 24 ++
 rtl/ram_rw_responder.sv | 114 +++++++++++
 2 files changed

// File: rtl/ram_rw_responder_if.sv
// rtl/ram_rw_responder_if.sv - ram_rw request/response port bundle
interface ram_rw_responder_if;
  logic        ram_rw_cen_i;
  logic        ram_rw_wen_i;
  logic [63:0] ram_rw_addr_i;
  logic [63:0] ram_rw_wdata_i;
  logic [7:0]  ram_rw_wmask_i;
  logic [2:0]  ram_rw_size_i;
  logic        ram_rw_ready_o;
  logic [63:0] ram_rw_data_o;
  logic        ram_rw_err_o;

  modport master (
    output ram_rw_cen_i, ram_rw_wen_i, ram_rw_addr_i, ram_rw_wdata_i,
           ram_rw_wmask_i, ram_rw_size_i,
    input  ram_rw_ready_o, ram_rw_data_o, ram_rw_err_o
  );

  modport slave (
    input  ram_rw_cen_i, ram_rw_wen_i, ram_rw_addr_i, ram_rw_wdata_i,
           ram_rw_wmask_i, ram_rw_size_i,
    output ram_rw_ready_o, ram_rw_data_o, ram_rw_err_o
  );
endinterface

// File: rtl/ram_rw_responder.sv
// rtl/ram_rw_responder.sv - fixed-latency 64-bit word RAM behind the ram_rw port
module ram_rw_responder #(
  parameter int          ADDR_W    = 12,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_rw_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

  logic [63:0]       mem_q [2**ADDR_W];
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              oor_q, oor_d;
  logic [63:0]       data_q, data_d;

  logic [64:0]       diff;
  logic [ADDR_W-1:0] in_idx;
  logic              in_oor;
  logic [7:0]        size_mask;
  logic [7:0]        eff_mask;
  logic              accept;
  logic              unused_bits;

  // 65-bit subtract so the borrow flags addresses below the base
  assign diff        = {1'b0, bus.ram_rw_addr_i} - {1'b0, BASE_ADDR};
  assign in_idx      = diff[ADDR_W+2:3];
  assign in_oor      = diff[64] | (|diff[63:ADDR_W+3]);
  assign accept      = (state_q == IDLE) && bus.ram_rw_cen_i;
  assign unused_bits = ^{diff[2:0], bus.ram_rw_size_i[2]};

  always_comb begin
    size_mask = 8'h01;
    case (bus.ram_rw_size_i[1:0])
      2'd0: size_mask = 8'h01;
      2'd1: size_mask = 8'h03;
      2'd2: size_mask = 8'h0F;
      2'd3: size_mask = 8'hFF;
      default: size_mask = 8'h01;
    endcase
  end

  // 8-bit shift drops lanes that would cross into the next word
  assign eff_mask = (bus.ram_rw_wmask_i != 8'h00) ? bus.ram_rw_wmask_i
                                                  : (size_mask << bus.ram_rw_addr_i[2:0]);

  always_ff @(posedge clk) begin
    if (rst_n && accept && bus.ram_rw_wen_i && !in_oor) begin
      for (int b = 0; b < 8; b++) begin
        if (eff_mask[b]) mem_q[in_idx][b*8 +: 8] <= bus.ram_rw_wdata_i[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.ram_rw_cen_i) begin
          wen_d   = bus.ram_rw_wen_i;
          idx_d   = in_idx;
          oor_d   = in_oor;
          cnt_d   = WAIT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Read word is captured on the edge entering RESP, then held
    if (state_d == RESP && state_q != RESP) begin
      data_d = (wen_d || oor_d) ? 64'd0 : mem_q[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      data_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      data_q  <= data_d;
    end
  end

  assign bus.ram_rw_ready_o = (state_q == RESP);
  assign bus.ram_rw_err_o   = (state_q == RESP) && oor_q;
  assign bus.ram_rw_data_o  = data_q;

endmodule
